// File: rtl/mul_mantissa_seq_if.sv
// Operand/product handshake bundle for the iterative mantissa multiplier.
// slave = multiplier side, master = the unpack/normalize stages around it.
interface mul_mantissa_seq_if #(
  parameter int WIDTH = 24
);
  logic               InValid;
  logic               InReady;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               OutValid;
  logic               OutReady;
  logic [2*WIDTH-1:0] Product;
  logic               Busy;

  modport slave (
    input  InValid, A, B, OutReady,
    output InReady, OutValid, Product, Busy
  );

  modport master (
    output InValid, A, B, OutReady,
    input  InReady, OutValid, Product, Busy
  );
endinterface

// File: rtl/mul_mantissa_seq.sv
// Radix-2 shift-and-add mantissa multiplier: one multiplier bit per cycle,
// WIDTH-bit ripple adder made from an array of full-adder cells.
module mul_mantissa_seq_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module mul_mantissa_seq #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_mantissa_seq_if.slave io
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_next, prod_q;
  logic [WIDTH-1:0]     m_q, addend, sum;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH:0]       carry;
  logic                 accept, last_step;

  // Adder step: accumulator + (P[0] ? M : 0); carry-out becomes the new MSB.
  assign addend   = p_q[0] ? m_q : '0;
  assign carry[0] = 1'b0;

  mul_mantissa_seq_fa u_fa [WIDTH-1:0] (
    .a  (p_q[2*WIDTH-1:WIDTH]),
    .b  (addend),
    .ci (carry[WIDTH-1:0]),
    .s  (sum),
    .co (carry[WIDTH:1])
  );

  assign p_next = {carry[WIDTH], sum, p_q[WIDTH-1:1]};

  assign io.InReady  = (state_q == IDLE) | ((state_q == DONE) & io.OutReady);
  assign io.OutValid = (state_q == DONE);
  assign io.Busy     = (state_q == RUN);
  assign io.Product  = prod_q;

  assign accept    = io.InValid & io.InReady;
  assign last_step = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last_step) state_d = DONE;
      DONE: if (io.OutReady) state_d = io.InValid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        m_q   <= io.A;
        p_q   <= {{WIDTH{1'b0}}, io.B};
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        p_q   <= p_next;
        cnt_q <= cnt_q + 1'b1;
        // Product is captured once so it stays put outside DONE.
        if (last_step) prod_q <= p_next;
      end
    end
  end
endmodule

// File: tb/tb_mul_mantissa_seq.sv
// Directed bench for mul_mantissa_seq (WIDTH=24): latency, products, stalls,
// back-to-back issue and asynchronous reset mid-operation.
module tb_mul_mantissa_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  mul_mantissa_seq_if #(.WIDTH(24)) io ();

  mul_mantissa_seq #(.WIDTH(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for exactly one edge, then drop InValid.
  task automatic issue(input logic [23:0] a, input logic [23:0] b);
    io.InValid = 1'b1;
    io.A = a;
    io.B = b;
    step();
    io.InValid = 1'b0;
  endtask

  // Edges elapsed until OutValid is seen, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (!io.OutValid && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    io.InValid  = 1'b0;
    io.A        = '0;
    io.B        = '0;
    io.OutReady = 1'b0;

    #12;
    chk("rst_inready",  io.InReady,  1);
    chk("rst_outvalid", io.OutValid, 0);
    chk("rst_busy",     io.Busy,     0);
    chk("rst_product",  io.Product,  0);
    rst_n = 1'b1;

    // 3*5 with downstream always ready
    io.OutReady = 1'b1;
    chk("t1_inready", io.InReady, 1);
    issue(24'd3, 24'd5);
    chk("t1_busy", io.Busy, 1);
    chk("t1_outvalid_run", io.OutValid, 0);
    wait_out(lat);
    chk("t1_latency", lat, 24);
    chk("t1_product", io.Product, 64'd15);
    step();
    chk("t1_idle_inready", io.InReady, 1);
    chk("t1_idle_outvalid", io.OutValid, 0);

    // Max operands
    issue(24'hFFFFFF, 24'hFFFFFF);
    wait_out(lat);
    chk("t2_max_latency", lat, 24);
    chk("t2_max_product", io.Product, 64'hFFFFFE000001);
    step();

    // 1.0 * 1.0
    issue(24'h800000, 24'h800000);
    wait_out(lat);
    chk("t2_one_product", io.Product, 64'h400000000000);
    step();

    // Zero multiplicand, InValid held with changing operands during RUN
    io.OutReady = 1'b0;
    io.InValid = 1'b1;
    io.A = 24'd0;
    io.B = 24'hABCDEF;
    step();
    lat = 0;
    while (!io.OutValid && lat < 100) begin
      io.A = 24'($urandom);
      io.B = 24'($urandom);
      if (lat == 5) chk("t3_run_inready", io.InReady, 0);
      step();
      lat++;
    end
    chk("t3_latency", lat, 24);
    chk("t3_product", io.Product, 64'd0);
    io.InValid = 1'b0;
    io.OutReady = 1'b1;
    step();
    chk("t3_idle", io.InReady, 1);

    // Downstream stall: 7*9 held for 10 cycles
    io.OutReady = 1'b0;
    issue(24'd7, 24'd9);
    wait_out(lat);
    chk("t4_latency", lat, 24);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", io.OutValid, 1);
      chk("t4_hold_product", io.Product, 64'd63);
      chk("t4_hold_inready", io.InReady, 0);
      step();
    end
    io.OutReady = 1'b1;
    #1;
    chk("t4_ready_comb", io.InReady, 1);
    step();
    chk("t4_idle_outvalid", io.OutValid, 0);
    chk("t4_idle_busy", io.Busy, 0);

    // Back-to-back: (2,3) then (4,5)
    io.InValid = 1'b1;
    io.A = 24'd2;
    io.B = 24'd3;
    step();
    io.A = 24'd4;
    io.B = 24'd5;
    wait_out(lat);
    chk("t5_first_latency", lat, 24);
    chk("t5_first_product", io.Product, 64'd6);
    step();
    chk("t5_reload_busy", io.Busy, 1);
    wait_out(lat);
    chk("t5_pulse_spacing", lat + 1, 25);
    chk("t5_second_product", io.Product, 64'd20);
    io.InValid = 1'b0;
    step();
    chk("t5_idle", io.OutValid, 0);

    // Reset at cycle 10 of RUN
    issue(24'hFFFFFF, 24'hFFFFFF);
    for (int i = 0; i < 9; i++) step();
    chk("t6_busy_before", io.Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_inready",  io.InReady,  1);
    chk("t6_rst_outvalid", io.OutValid, 0);
    chk("t6_rst_busy",     io.Busy,     0);
    chk("t6_rst_product",  io.Product,  0);
    #2;
    rst_n = 1'b1;
    issue(24'd2, 24'd2);
    wait_out(lat);
    chk("t6_after_latency", lat, 24);
    chk("t6_after_product", io.Product, 64'd4);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
